// File: rtl/keypad_scan_pkg.sv
// Shared encodings for the keypad scanner: FSM states, frame results and key-code helpers.
package keypad_scan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_HIT   = 2'd1,
    FR_MULTI = 2'd2
  } frame_res_e;

  // Key codes 0..15 are row*4 + col.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Number of active-low (pressed) bits in a column sample.
  function automatic logic [2:0] low_count(input logic [3:0] col_n);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_COLS; i++) n = n + {2'b00, ~col_n[i]};
    return n;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running divider producing a one-cycle enable every SCAN_DIV+1 clocks.
module scan_tick_gen #(
  parameter logic [24:0] SCAN_DIV = 25'd49_999
) (
  input  logic Clk,
  input  logic Reset,
  output logic tick
);

  logic [24:0] cnt;

  assign tick = (cnt == SCAN_DIV);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 25'd1;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row rotation, per-frame press classification and debounce FSM.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter logic [24:0] SCAN_DIV   = 25'd49_999,
  parameter logic [3:0]  DEB_FRAMES = 4'd4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic [3:0] Key_code,
  output logic       Key_valid,
  output logic       Key_held
);

  logic [3:0] col_meta, col_sync;
  logic       tick;
  logic [1:0] row_idx;
  logic       acc_any, acc_multi;
  logic [3:0] acc_code;
  kp_state_e  state;
  logic [3:0] cnt, cand;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .Clk  (Clk),
    .Reset(Reset),
    .tick (tick)
  );

  assign Row = ~(4'b0001 << row_idx);

  // Fold the current row sample into the frame so far; a frame is judged on the row-3 tick.
  logic [3:0] row_low;
  logic [2:0] row_n;
  logic [1:0] col_i;
  logic       frm_any, frm_multi, frame_end;
  logic [3:0] frm_code, cnt_nxt;
  frame_res_e frm_res;

  always_comb begin
    row_low = ~col_sync;
    row_n   = low_count(col_sync);
    col_i   = 2'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--)
      if (row_low[c]) col_i = 2'(c);
    frm_any   = acc_any | (row_n != 3'd0);
    frm_multi = acc_multi | (row_n > 3'd1) | (acc_any & (row_n != 3'd0));
    frm_code  = (row_n != 3'd0) ? key_code(row_idx, col_i) : acc_code;
    frm_res   = frm_multi ? FR_MULTI : (frm_any ? FR_HIT : FR_NONE);
    frame_end = tick && (row_idx == 2'd3);
    cnt_nxt   = cnt + 4'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col_meta  <= 4'hF;
      col_sync  <= 4'hF;
      row_idx   <= 2'd0;
      acc_any   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= 4'd0;
    end else begin
      col_meta <= Col;
      col_sync <= col_meta;
      if (tick) begin
        row_idx <= row_idx + 2'd1;
        if (row_idx == 2'd3) begin
          acc_any   <= 1'b0;
          acc_multi <= 1'b0;
          acc_code  <= 4'd0;
        end else begin
          acc_any   <= frm_any;
          acc_multi <= frm_multi;
          acc_code  <= frm_code;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'd0;
      Key_code  <= 4'd0;
      Key_valid <= 1'b0;
      Key_held  <= 1'b0;
    end else begin
      Key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: if (frm_res == FR_HIT) begin
            state <= DEBOUNCE;
            cand  <= frm_code;
            cnt   <= 4'd1;
          end
          DEBOUNCE: if (frm_res == FR_HIT && frm_code == cand) begin
            if (cnt_nxt == DEB_FRAMES) begin
              state     <= PRESSED;
              cnt       <= 4'd0;
              Key_code  <= cand;
              Key_valid <= 1'b1;
              Key_held  <= 1'b1;
            end else begin
              cnt <= cnt_nxt;
            end
          end else begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
          // Any activity, even a different or second key, keeps the original press held.
          PRESSED: if (frm_res == FR_NONE) begin
            state <= RELEASE;
            cnt   <= 4'd1;
          end
          RELEASE: if (frm_res == FR_NONE) begin
            if (cnt_nxt == DEB_FRAMES) begin
              state    <= IDLE;
              cnt      <= 4'd0;
              Key_held <= 1'b0;
            end else begin
              cnt <= cnt_nxt;
            end
          end else begin
            state <= PRESSED;
            cnt   <= 4'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized/directed keypad bench: frame-level reference model feeds an event scoreboard.
module tb_keypad_scan;

  localparam int DEB   = 3;
  localparam int TICK  = 10;
  localparam int FRAME = 4 * TICK;

  typedef struct {
    bit         rel;
    logic [3:0] code;
    int         cyc;
  } ev_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  Col, Row, Key_code;
  logic        Key_valid, Key_held;
  logic [15:0] pressed = '0;

  int  cyc;
  int  n_tests = 0;
  int  n_fail = 0;
  int  fidx;
  ev_t exp_q[$];
  bit  prev_held;

  // Reference model state: frame-level view of the keypad.
  bit         m_held;
  int         m_streak, m_rel;
  logic [3:0] m_cand, m_last;

  keypad_scan #(.SCAN_DIV(25'd9), .DEB_FRAMES(4'd3)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Col      (Col),
    .Row      (Row),
    .Key_code (Key_code),
    .Key_valid(Key_valid),
    .Key_held (Key_held)
  );

  always #5 Clk = ~Clk;

  // Physical keypad: a pressed key shorts its column to the driven-low row.
  always_comb begin
    Col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!Row[r] && pressed[r*4+c]) Col[c] = 1'b0;
  end

  always @(posedge Clk) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One frame with a constant key set: classify it, then advance the debounce model.
  task automatic model_frame(input logic [15:0] mask);
    int n;
    logic [3:0] code;
    ev_t e;
    fidx++;
    n = $countones(mask);
    code = 4'd0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = 4'(i);
    if (!m_held) begin
      if (n == 1) begin
        if (m_streak > 0 && code != m_cand) m_streak = 0;
        else begin
          m_streak = m_streak + 1;
          m_cand   = code;
        end
        if (m_streak == DEB) begin
          m_held = 1; m_streak = 0; m_last = code;
          e.rel = 0; e.code = code; e.cyc = FRAME * fidx;
          exp_q.push_back(e);
        end
      end else m_streak = 0;
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == DEB) begin
          m_held = 0; m_rel = 0;
          e.rel = 1; e.code = m_last; e.cyc = FRAME * fidx;
          exp_q.push_back(e);
        end
      end else m_rel = 0;
    end
  endtask

  task automatic frames(input logic [15:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      pressed = mask;
      model_frame(mask);
      repeat (FRAME) @(negedge Clk);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_row", Row, 4'b1110);
    check("rst_code", Key_code, 0);
    check("rst_valid", Key_valid, 0);
    check("rst_held", Key_held, 0);
    m_held = 0; m_streak = 0; m_rel = 0; m_cand = '0;
    fidx = 0;
    prev_held = 0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Monitor: row rotation every cycle, and every Key_valid / Key_held fall against the queue.
  always @(negedge Clk) begin
    if (!Reset) begin
      ev_t e;
      check("row", Row, (~(1 << ((cyc / TICK) % 4))) & 15);
      if (Key_valid) begin
        if (exp_q.size() == 0) check("unexpected_press", Key_code, -1);
        else begin
          e = exp_q.pop_front();
          check("press_kind", 0, int'(e.rel));
          check("press_code", Key_code, e.code);
          check("press_cycle", cyc, e.cyc);
          check("press_held", Key_held, 1);
        end
      end else if (prev_held && !Key_held) begin
        if (exp_q.size() == 0) check("unexpected_release", Key_code, -1);
        else begin
          e = exp_q.pop_front();
          check("release_kind", 1, int'(e.rel));
          check("release_code", Key_code, e.code);
          check("release_cycle", cyc, e.cyc);
        end
      end else if (!prev_held && Key_held) begin
        check("held_without_valid", 1, 0);
      end
      prev_held = Key_held;
    end
  end

  initial begin
    logic [15:0] m;
    int k1, k2, sel;
    #1;
    do_reset();

    frames(16'h0000, 4);                      // idle
    frames(16'h0001 << 9, 4);                 // row 2 col 1 held
    frames(16'h0000, 4);                      // release
    frames(16'h0001 << 3, 2);                 // bounce on key 3
    frames(16'h0000, 1);
    frames(16'h0001 << 3, 3);
    frames(16'h0000, 3);
    frames((16'h0001 << 5) | (16'h0001 << 10), 3);  // two keys -> MULTI
    frames(16'h0001 << 5, 3);
    frames(16'h0000, 3);

    // Reset two frames into a debounce, part-way through the third.
    frames(16'h0001 << 6, 2);
    repeat (15) @(negedge Clk);
    do_reset();
    frames(16'h0001 << 6, 3);
    frames(16'h0000, 3);

    for (int r = 0; r < 14; r++) begin
      sel = int'($urandom_range(0, 2));
      k1  = int'($urandom_range(0, 15));
      k2  = (k1 + int'($urandom_range(1, 15))) % 16;
      m   = '0;
      if (sel >= 1) m[k1] = 1'b1;
      if (sel == 2) m[k2] = 1'b1;
      frames(m, int'($urandom_range(1, 4)));
    end
    frames(16'h0000, 3);

    repeat (5) @(negedge Clk);
    check("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad by driving one row low at a time and reading the four column inputs.
- Debounces detected presses and presents a 4-bit key code to the ALU operand/opcode entry logic.
- Input-side companion of the multiplexed 7-segment display path: the display writes digits through time-multiplexed selects, and this block reads keys through time-multiplexed row drives.
- Single clock domain; the keypad columns are asynchronous inputs.

Parameters:
- SCAN_DIV, 25'd49_999, scan tick every SCAN_DIV+1 Clk cycles (1 ms at 50 MHz); must be >= 3.
- DEB_FRAMES, 4'd4, consecutive identical frames required to accept a press or a release; must be >= 2.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- Col  input  4  keypad columns, active-low (pulled up externally), asynchronous.
- Row  output  4  row drive, active-low one-hot.
- Key_code  output  4  code of the accepted key: row*4 + col.
- Key_valid  output  1  one-Clk pulse when a press is accepted.
- Key_held  output  1  high from press acceptance until release acceptance.

Behaviour:
- Reset values: Row=4'b1110, Key_code=0, Key_valid=0, Key_held=0, tick counter=0, row index=0, FSM=IDLE, debounce count=0, candidate=0.
- Col passes through a 2-flop synchronizer before any use.
- Tick:
  - Internal counter runs 0..SCAN_DIV; tick asserts for one Clk cycle when the counter equals SCAN_DIV, then the counter wraps to 0.
  - The tick is an enable; no derived clocks.
- On tick, sample synchronized Col for the current row index, then advance the row: 0->1->2->3->0, with Row=~(1<<idx).
  - SCAN_DIV >= 3 guarantees Col has settled through the synchronizer.
- Frame:
  - Four consecutive ticks (rows 0..3) form one frame, evaluated on the tick that samples row 3.
  - Frame result is one of:
    - NONE: no low column in any row.
    - HIT(code): exactly one low bit across the whole frame; code = row*4 + col index.
    - MULTI: two or more low bits. MULTI is treated as NONE for press qualification and as not-NONE for release qualification.
- FSM, updated only at frame end:
  - IDLE: HIT(c) -> DEBOUNCE, cand=c, cnt=1. Otherwise stay.
  - DEBOUNCE: HIT(cand) -> cnt+1. If cnt+1 == DEB_FRAMES -> PRESSED, with Key_code=cand, Key_valid pulse, Key_held=1. Any other result -> IDLE, cnt=0.
  - PRESSED: NONE -> RELEASE, cnt=1. HIT (any code) or MULTI -> stay. Key_code is unchanged; a second key is not reported.
  - RELEASE: NONE -> cnt+1. If cnt+1 == DEB_FRAMES -> IDLE, Key_held=0, cnt=0. HIT or MULTI -> PRESSED, cnt=0, no new Key_valid.
- Key_valid is high exactly one Clk cycle: the cycle after the accepting frame-end tick. Key_code and Key_held update in that same cycle.
- Key_code holds its last accepted value after release.
- Latency: a clean press is accepted DEB_FRAMES frames after the first frame containing it, plus 1 Clk cycle.
- Reset asserted mid-scan or mid-debounce returns all state to reset values immediately (asynchronously). Scanning restarts at row 0 after deassertion.
- Debounce counter width is 4 bits; it never exceeds DEB_FRAMES.

Decomposition:
- Shared constants header:
  - FSM state encodings: IDLE=2'd0, DEBOUNCE=2'd1, PRESSED=2'd2, RELEASE=2'd3.
  - Frame result encodings.
  - Key code map: 0..15 = row*4 + col.
- One sub-module, scan_tick_gen: parameterized by SCAN_DIV; inputs Clk and Reset; output a 1-cycle tick enable. Reusable by the display multiplexer.
- Synchronizer, row rotation, frame accumulator and FSM live in keypad_scan.

Test Plan (SCAN_DIV=9, DEB_FRAMES=3, so tick every 10 cycles and frame every 40 cycles):
- Reset then idle, Col=4'b1111:
  - Row cycles 1110, 1101, 1011, 0111, changing every 10 cycles.
  - Key_valid stays 0 and Key_held stays 0.
- Key row 2, col 1 held steady (model pulls Col[1] low while Row[2]=0):
  - Exactly one Key_valid pulse with Key_code=4'd9, Key_held=1.
  - The pulse occurs 1 cycle after the end of the 3rd frame containing the key.
- Release after the accepted press:
  - Key_held falls 1 cycle after the 3rd consecutive NONE frame.
  - No Key_valid pulse on release; Key_code remains 9.
- Bounce: key row 0, col 3 present for 2 frames, absent for 1, present for 3:
  - A single Key_valid with Key_code=4'd3, accepted only after the final 3 frames.
- Two keys (codes 5 and 10) pressed together from IDLE:
  - MULTI every frame, so no Key_valid.
  - Release key 10: Key_valid with Key_code=5 after 3 frames.
- Reset asserted mid-DEBOUNCE (after 2 HIT frames):
  - Outputs go to reset values immediately and Row=1110.
  - After deassertion, a full 3 frames are needed before Key_valid.
